cm0_dap_ap_req_ctrl: RTL and testbench

AP-side transaction sequencer for the debug access port. It sits directly behind the AP clock-domain-crossing stage. It detects a new DP request from the synchronised request/acknowledge toggle pair and opens the CDC output mask to capture the request. It then issues a single register access to the downstream AP register/bus engine, loads the result into the CDC launch registers, and finally toggles the acknowledge. All logic runs on the AP clock. The block generates every control strobe the CDC stage consumes (`ap_out_en`, `ap_wr_en`, `ap_ack_load`).

---
 rtl/cm0_dap_ap_req_ctrl.sv | 108 ++++++++++
 tb/tb_cm0_dap_ap_req_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cm0_dap_ap_req_ctrl.sv
// AP-side request sequencer: detects a DP request toggle, runs one downstream
// register access, loads the response into the CDC launch registers, then acks.
module cm0_dap_ap_req_ctrl #(
    parameter int PRESENT = 1,
    parameter int TIMEOUT = 255
) (
    input  logic        dclk,
    input  logic        apreset,
    input  logic        dp_req_ap_i,
    input  logic        ap_ack_ap_i,
    input  logic        dp_rnw_ap_i,
    input  logic [3:0]  dp_regaddr_ap_i,
    input  logic [31:0] dp_data_ap_i,
    output logic        ap_out_en_o,
    output logic        ap_wr_en_o,
    output logic        ap_ack_load_o,
    output logic [31:0] ap_data_ap_o,
    output logic        ap_err_ap_o,
    output logic        reg_req_o,
    output logic        reg_rnw_o,
    output logic [3:0]  reg_addr_o,
    output logic [31:0] reg_wdata_o,
    input  logic [31:0] reg_rdata_i,
    input  logic        reg_err_i,
    input  logic        reg_done_i
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CAPT,
        S_EXEC,
        S_RESP,
        S_ACK
    } state_t;

    localparam logic       EN  = (PRESENT != 0);
    localparam logic [7:0] TMO = 8'(TIMEOUT);

    state_t      state;
    state_t      state_nx;
    logic [7:0]  cnt;
    logic [7:0]  cnt_inc;
    logic        pending;
    logic        timeout;

    assign pending = dp_req_ap_i ^ ap_ack_ap_i;
    // Saturating increment; timeout compares the count including this cycle.
    assign cnt_inc = (cnt == 8'hFF) ? cnt : cnt + 8'd1;
    assign timeout = (cnt_inc == TMO);

    // NOTE: next state gets a default before the case so no latch is inferred.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (pending) state_nx = S_CAPT;
            S_CAPT:  state_nx = S_EXEC;
            S_EXEC:  if (reg_done_i || timeout) state_nx = S_RESP;
            S_RESP:  state_nx = S_ACK;
            S_ACK:   state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
        if (!EN) state_nx = S_IDLE;
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge dclk) begin
        if (apreset) state <= S_IDLE;
        else         state <= state_nx;
    end

    always_ff @(posedge dclk) begin
        if (apreset) begin
            cnt          <= 8'd0;
            reg_rnw_o    <= 1'b0;
            reg_addr_o   <= 4'd0;
            reg_wdata_o  <= 32'd0;
            ap_data_ap_o <= 32'd0;
            ap_err_ap_o  <= 1'b0;
        end else if (EN) begin
            case (state)
                S_CAPT: begin
                    reg_rnw_o   <= dp_rnw_ap_i;
                    reg_addr_o  <= dp_regaddr_ap_i;
                    reg_wdata_o <= dp_data_ap_i;
                    cnt         <= 8'd0;
                end
                S_EXEC: begin
                    cnt <= cnt_inc;
                    // Completion has priority over a coincident timeout.
                    if (reg_done_i) begin
                        ap_data_ap_o <= reg_rnw_o ? reg_rdata_i : 32'd0;
                        ap_err_ap_o  <= reg_err_i;
                    end else if (timeout) begin
                        ap_data_ap_o <= 32'd0;
                        ap_err_ap_o  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign ap_out_en_o   = EN && (state == S_CAPT);
    assign reg_req_o     = EN && (state == S_EXEC);
    assign ap_wr_en_o    = EN && (state == S_RESP);
    assign ap_ack_load_o = EN && (state == S_ACK);

endmodule

// File: tb/tb_cm0_dap_ap_req_ctrl.sv
// Directed bench for cm0_dap_ap_req_ctrl: read, write with error, timeout,
// back-to-back, reset mid-transaction, and a PRESENT=0 instance.
module tb_cm0_dap_ap_req_ctrl;

    logic        dclk;
    logic        apreset;
    logic        dp_req;
    logic        ap_ack;
    logic        dp_rnw;
    logic [3:0]  dp_addr;
    logic [31:0] dp_data;
    logic [31:0] reg_rdata;
    logic        reg_err;
    logic        reg_done;

    logic        out_en, wr_en, ack_load, err, req, rnw;
    logic [31:0] data, wdata;
    logic [3:0]  addr;

    logic        np_out_en, np_wr_en, np_ack_load, np_err, np_req, np_rnw;
    logic [31:0] np_data, np_wdata;
    logic [3:0]  np_addr;

    int total = 0;
    int bad   = 0;
    int wr_cnt  = 0;
    int ack_cnt = 0;
    int wr_base, ack_base;

    cm0_dap_ap_req_ctrl #(.PRESENT(1), .TIMEOUT(4)) dut (
        .dclk(dclk), .apreset(apreset),
        .dp_req_ap_i(dp_req), .ap_ack_ap_i(ap_ack),
        .dp_rnw_ap_i(dp_rnw), .dp_regaddr_ap_i(dp_addr), .dp_data_ap_i(dp_data),
        .ap_out_en_o(out_en), .ap_wr_en_o(wr_en), .ap_ack_load_o(ack_load),
        .ap_data_ap_o(data), .ap_err_ap_o(err),
        .reg_req_o(req), .reg_rnw_o(rnw), .reg_addr_o(addr), .reg_wdata_o(wdata),
        .reg_rdata_i(reg_rdata), .reg_err_i(reg_err), .reg_done_i(reg_done)
    );

    cm0_dap_ap_req_ctrl #(.PRESENT(0), .TIMEOUT(4)) dut_np (
        .dclk(dclk), .apreset(apreset),
        .dp_req_ap_i(dp_req), .ap_ack_ap_i(ap_ack),
        .dp_rnw_ap_i(dp_rnw), .dp_regaddr_ap_i(dp_addr), .dp_data_ap_i(dp_data),
        .ap_out_en_o(np_out_en), .ap_wr_en_o(np_wr_en), .ap_ack_load_o(np_ack_load),
        .ap_data_ap_o(np_data), .ap_err_ap_o(np_err),
        .reg_req_o(np_req), .reg_rnw_o(np_rnw), .reg_addr_o(np_addr), .reg_wdata_o(np_wdata),
        .reg_rdata_i(reg_rdata), .reg_err_i(reg_err), .reg_done_i(reg_done)
    );

    initial dclk = 1'b0;
    always #5 dclk = ~dclk;

    // CDC acknowledge flop, modelled as a toggle so a second DP toggle stays visible.
    always @(posedge dclk) begin
        if (apreset)       ap_ack <= 1'b0;
        else if (ack_load) ap_ack <= ~ap_ack;
    end

    always @(negedge dclk) begin
        if (wr_en)    wr_cnt  <= wr_cnt + 1;
        if (ack_load) ack_cnt <= ack_cnt + 1;
    end

    task automatic tick();
        @(posedge dclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        apreset = 1'b1; dp_req = 1'b0; dp_rnw = 1'b0; dp_addr = 4'd0; dp_data = 32'd0;
        reg_rdata = 32'd0; reg_err = 1'b0; reg_done = 1'b0;
        tick(); tick();
        chk("rst_out_en", out_en, 0);
        chk("rst_req", req, 0);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_ack_load", ack_load, 0);
        chk("rst_data", data, 0);
        chk("rst_err", err, 0);
        chk("rst_addr", addr, 0);
        chk("rst_wdata", wdata, 0);
        apreset = 1'b0;
        tick();

        // Read, done in the first EXEC cycle
        dp_rnw = 1'b1; dp_addr = 4'hC; dp_data = 32'd0; dp_req = ~dp_req;
        chk("rd_c0_out_en", out_en, 0);
        tick();
        chk("rd_c1_out_en", out_en, 1);
        chk("rd_c1_req", req, 0);
        tick();
        chk("rd_c2_req", req, 1);
        chk("rd_c2_rnw", rnw, 1);
        chk("rd_c2_addr", addr, 4'hC);
        reg_done = 1'b1; reg_rdata = 32'hDEADBEEF; reg_err = 1'b0;
        tick();
        reg_done = 1'b0; reg_rdata = 32'd0;
        chk("rd_c3_wr_en", wr_en, 1);
        chk("rd_c3_data", data, 32'hDEADBEEF);
        chk("rd_c3_err", err, 0);
        chk("rd_c3_req", req, 0);
        tick();
        chk("rd_c4_ack_load", ack_load, 1);
        chk("rd_c4_wr_en", wr_en, 0);
        tick();
        chk("rd_c5_ack_load", ack_load, 0);
        chk("rd_c5_out_en", out_en, 0);
        tick();
        chk("rd_c6_no_reentry", out_en, 0);
        chk("rd_wr_cnt", wr_cnt, 1);
        chk("rd_ack_cnt", ack_cnt, 1);

        // Write with error after three EXEC cycles; done during CAPT is ignored
        dp_rnw = 1'b0; dp_addr = 4'h4; dp_data = 32'h12345678; dp_req = ~dp_req;
        tick();
        reg_done = 1'b1; reg_rdata = 32'h0BAD0BAD; reg_err = 1'b1;
        tick();
        reg_done = 1'b0; reg_err = 1'b0; reg_rdata = 32'hFFFFFFFF;
        chk("wr_exec1_req", req, 1);
        chk("wr_done_ignored_capt", data, 32'hDEADBEEF);
        chk("wr_wdata", wdata, 32'h12345678);
        chk("wr_rnw", rnw, 0);
        chk("wr_addr", addr, 4'h4);
        tick();
        chk("wr_exec2_req", req, 1);
        tick();
        reg_done = 1'b1; reg_err = 1'b1;
        tick();
        reg_done = 1'b0; reg_err = 1'b0;
        chk("wr_resp_wr_en", wr_en, 1);
        chk("wr_resp_data", data, 0);
        chk("wr_resp_err", err, 1);
        tick(); tick();
        chk("wr_wr_cnt", wr_cnt, 2);

        // Timeout with TIMEOUT=4: exactly four request cycles
        dp_rnw = 1'b1; dp_addr = 4'h8; reg_rdata = 32'hA5A5A5A5; dp_req = ~dp_req;
        tick();
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("to_req_%0d", i), req, 1);
        end
        tick();
        chk("to_req_drop", req, 0);
        chk("to_wr_en", wr_en, 1);
        chk("to_err", err, 1);
        chk("to_data", data, 0);
        tick(); tick();

        // Done coincident with timeout wins
        dp_req = ~dp_req;
        tick();
        tick(); tick(); tick();
        tick();
        reg_done = 1'b1; reg_rdata = 32'hCAFEF00D; reg_err = 1'b0;
        tick();
        reg_done = 1'b0;
        chk("to_done_wr_en", wr_en, 1);
        chk("to_done_data", data, 32'hCAFEF00D);
        chk("to_done_err", err, 0);
        tick(); tick();

        // Back-to-back: second toggle during EXEC of the first
        ack_base = ack_cnt;
        dp_rnw = 1'b1; dp_addr = 4'h1; dp_req = ~dp_req;
        tick();
        tick();
        dp_req = ~dp_req; dp_rnw = 1'b0; dp_addr = 4'h2; dp_data = 32'h55AA55AA;
        reg_done = 1'b1; reg_rdata = 32'h11112222; reg_err = 1'b0;
        tick();
        reg_done = 1'b0;
        chk("b2b_a_data", data, 32'h11112222);
        tick();
        tick();
        chk("b2b_idle_out_en", out_en, 0);
        tick();
        chk("b2b_b_capt", out_en, 1);
        tick();
        chk("b2b_b_addr", addr, 4'h2);
        chk("b2b_b_wdata", wdata, 32'h55AA55AA);
        chk("b2b_b_rnw", rnw, 0);
        reg_done = 1'b1;
        tick();
        reg_done = 1'b0;
        chk("b2b_b_data", data, 0);
        tick(); tick(); tick();
        chk("b2b_no_third", out_en, 0);
        chk("b2b_ack_cnt", ack_cnt - ack_base, 2);

        // Reset during EXEC abandons the transaction
        dp_rnw = 1'b1; dp_addr = 4'h3; dp_req = ~dp_req;
        tick();
        tick();
        chk("rst_exec_req", req, 1);
        wr_base = wr_cnt; ack_base = ack_cnt;
        apreset = 1'b1; dp_req = 1'b0;
        tick();
        apreset = 1'b0;
        chk("rstx_req", req, 0);
        chk("rstx_out_en", out_en, 0);
        chk("rstx_wr_en", wr_en, 0);
        chk("rstx_ack_load", ack_load, 0);
        chk("rstx_addr", addr, 0);
        chk("rstx_rnw", rnw, 0);
        tick(); tick(); tick(); tick();
        chk("rstx_no_wr", wr_cnt - wr_base, 0);
        chk("rstx_no_ack", ack_cnt - ack_base, 0);
        chk("rstx_idle", out_en, 0);

        dp_rnw = 1'b1; dp_addr = 4'h7; dp_req = 1'b1;
        tick();
        chk("post_capt", out_en, 1);
        tick();
        chk("post_addr", addr, 4'h7);
        reg_done = 1'b1; reg_rdata = 32'h76543210; reg_err = 1'b0;
        tick();
        reg_done = 1'b0;
        chk("post_wr_en", wr_en, 1);
        chk("post_data", data, 32'h76543210);
        tick();
        chk("post_ack_load", ack_load, 1);
        tick(); tick();

        // PRESENT=0 instance stays silent under random stimulus
        for (int i = 0; i < 40; i++) begin
            dp_req    = 1'($urandom);
            dp_rnw    = 1'($urandom);
            dp_addr   = 4'($urandom);
            dp_data   = $urandom;
            reg_rdata = $urandom;
            reg_err   = 1'($urandom);
            reg_done  = 1'($urandom);
            tick();
            chk("np_ctl", {26'd0, np_out_en, np_wr_en, np_ack_load, np_req, np_rnw, np_err}, 0);
            chk("np_bus", np_data | np_wdata | {28'd0, np_addr}, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
